div32_seq: RTL and testbench
============================

DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a division; sampled on the rising edge.
REQ-005 Port: dividend  input  WIDTH  unsigned dividend; sampled with start.
REQ-006 Port: divisor  input  WIDTH  unsigned divisor; sampled with start.
REQ-007 Port: busy  output  1  high while an iteration is in progress.
REQ-008 Port: done  output  1  one-cycle pulse; results valid.
REQ-009 Port: quotient  output  WIDTH  unsigned quotient.
REQ-010 Port: remainder  output  WIDTH  unsigned remainder.
REQ-011 Port: div_by_zero  output  1  divisor sampled as zero; qualified by done.

Function
REQ-012 The block SHALL be an unsigned restoring divider retiring one quotient bit per CALC cycle, MSB first.
REQ-013 The FSM SHALL have the states IDLE, CALC and DONE, with all outputs registered.
REQ-014 IDLE or DONE with start=1, divisor!=0: capture operands, clear the partial remainder, load the iteration counter with WIDTH-1, and go to CALC.
REQ-015 IDLE or DONE with start=1, divisor==0: go to DONE directly, with quotient={WIDTH{1}}, remainder=dividend and div_by_zero=1.
REQ-016 Each CALC cycle SHALL do the following: form the trial value {partial_rem, next dividend bit}, subtract the divisor, and act on the borrow.
REQ-017 If borrow=0: keep the difference and shift a 1 into the quotient.
REQ-018 If borrow=1: keep the trial value and shift a 0 into the quotient.
REQ-019 CALC SHALL last exactly WIDTH cycles; when counter==0, go to DONE.
REQ-020 done SHALL be high only in DONE, for exactly one cycle.
REQ-021 Timing, normal case: done visible after the WIDTH-th edge following the start-sampling edge.
REQ-022 Timing, divide-by-zero: done visible after the first edge.
REQ-023 DONE SHALL return to IDLE on the next edge unless start=1, in which case REQ-014 or REQ-015 applies (back-to-back operation).
REQ-024 busy SHALL be 1 in CALC and 0 otherwise.
REQ-025 start asserted while busy=1 SHALL be ignored, with no capture and no effect on the operation in flight.
REQ-026 quotient, remainder and div_by_zero SHALL hold their last values from DONE until the next accepted start.
REQ-027 div_by_zero SHALL clear on the next accepted start with a nonzero divisor.
REQ-028 Operand changes while busy SHALL have no effect on results.
REQ-029 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every nonzero divisor.
REQ-030 Partial-remainder arithmetic SHALL be WIDTH+1 bits internally so that the shifted trial value never overflows.

Reset
REQ-031 When reset=1 at a rising edge, the state SHALL become IDLE, regardless of the current state.
REQ-032 The same reset edge SHALL force busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear all internal registers.
REQ-033 Reset SHALL take priority over start.
REQ-034 Reset asserted mid-CALC SHALL abandon the operation with no done pulse.
REQ-035 The first start is accepted on the edge after reset deasserts.

Structure
REQ-036 The state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the WIDTH default SHALL live in the shared package div_pkg.
REQ-037 The trial subtraction SHALL be a separate sub-module, sub33.
REQ-038 sub33 SHALL be a (WIDTH+1)-bit subtractor computing a + ~b + 1 on the team's carry-look-ahead adder cells, with outputs diff and borrow.
REQ-039 sub33 SHALL be combinational; the path from register through sub33 back to register SHALL close in one cycle.

Verification
REQ-040 Basic divide: dividend=100, divisor=7, start one cycle -> after 32 edges done=1, quotient=14, remainder=2, div_by_zero=0; busy high for 32 cycles.
REQ-041 Maximum dividend: dividend=32'hFFFF_FFFF, divisor=1 -> quotient=32'hFFFF_FFFF, remainder=0.
REQ-042 Dividend smaller than divisor: dividend=3, divisor=10 -> quotient=0, remainder=3.
REQ-043 Divide by zero: dividend=5, divisor=0 -> done after 1 edge, div_by_zero=1, quotient=32'hFFFF_FFFF, remainder=5, busy never high.
REQ-044 Ignored start: start with 100/7, then at cycle 10 start with 9/3 -> results still 14/2; the second start is ignored.
REQ-045 Reset mid-operation and restart: reset at cycle 15 of an operation -> next cycle busy=0 and all outputs 0, no done pulse; then back-to-back starts 50/5 and 7/2 (second start in DONE) -> 10/0 then 3/1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider:
// default width and FSM state encodings.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/sub33.sv
// Combinational N-bit subtractor a + ~b + 1 built from
// 4-bit carry-look-ahead groups chained group to group.
module sub33 #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N-1:0] w_bn;
  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N:0]   w_c;
  logic         w_gg;
  logic         w_pp;
  logic         w_cg;

  assign w_bn = ~b;
  assign w_g  = a & w_bn;
  assign w_p  = a ^ w_bn;

  // Inside a group each carry is generate/propagate
  // prefix of the group against the group carry-in.
  always_comb begin
    w_c    = '0;
    w_c[0] = 1'b1;
    w_gg   = 1'b0;
    w_pp   = 1'b1;
    w_cg   = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i % 4 == 0) begin
        w_gg = 1'b0;
        w_pp = 1'b1;
        w_cg = w_c[i];
      end
      w_gg     = w_g[i] | (w_p[i] & w_gg);
      w_pp     = w_p[i] & w_pp;
      w_c[i+1] = w_gg | (w_pp & w_cg);
    end
  end

  assign diff   = w_p ^ w_c[N-1:0];
  assign borrow = ~w_c[N];

endmodule

// File: rtl/div32_seq.sv
// Unsigned restoring divider, one quotient bit per cycle,
// MSB first; the dividend register doubles as quotient.
import div_pkg::*;

module div32_seq #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       r_state;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rmd;
  logic             r_dbz;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_next_rem;
  logic [WIDTH-1:0] w_next_quo;
  logic             w_unused;

  assign w_trial = {r_rem, r_dvd[WIDTH-1]};

  sub33 #(.N(WIDTH + 1)) u_sub (
    .a      (w_trial),
    .b      ({1'b0, r_dvs}),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  // Remainder stays below the divisor, so the top bit is always 0.
  assign w_next_rem = w_borrow ? w_trial[WIDTH-1:0]
                               : w_diff[WIDTH-1:0];
  assign w_next_quo = {r_dvd[WIDTH-2:0], ~w_borrow};
  assign w_unused   = w_diff[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quo   <= '0;
      r_rmd   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
          if (start) begin
            if (divisor == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quo   <= '1;
              r_rmd   <= dividend;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_dvd   <= dividend;
              r_dvs   <= divisor;
              r_rem   <= '0;
              r_cnt   <= CW'(WIDTH - 1);
              r_busy  <= 1'b1;
              r_dbz   <= 1'b0;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_next_rem;
          r_dvd <= w_next_quo;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quo   <= w_next_quo;
            r_rmd   <= w_next_rem;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quo;
  assign remainder   = r_rmd;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div32_seq.sv
// Directed checks of div32_seq: timing, results, div-by-zero,
// ignored start, mid-operation reset and back-to-back starts.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad = 0;

  div32_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n = edges after the current sample point until done; -1 on timeout
  task automatic wait_done(output int n, output int nbusy);
    n = -1;
    nbusy = 0;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
      bad++;
      $display("FAIL reset_outputs got b=%b d=%b q=%h r=%h z=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int n, nb;
    do_start(32'd100, 32'd7);
    wait_done(n, nb);
    total++;
    if (n !== 32) begin
      bad++;
      $display("FAIL basic_latency got %0d want 32", n);
    end
    total++;
    if (nb !== 32) begin
      bad++;
      $display("FAIL basic_busy_cycles got %0d want 32", nb);
    end
    total++;
    if ({quotient, remainder, div_by_zero} !== {32'd14, 32'd2, 1'b0}) begin
      bad++;
      $display("FAIL basic_result got q=%0d r=%0d z=%b want 14 2 0",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    total++;
    if ({done, busy, quotient, remainder} !== {2'b00, 32'd14, 32'd2}) begin
      bad++;
      $display("FAIL basic_pulse_hold got d=%b b=%b q=%0d r=%0d want 0 0 14 2",
               done, busy, quotient, remainder);
    end
  endtask

  task automatic test_max;
    int n, nb;
    do_start(32'hFFFF_FFFF, 32'd1);
    wait_done(n, nb);
    total++;
    if (n !== 32 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin
      bad++;
      $display("FAIL max_dividend got n=%0d q=%h r=%h want 32 ffffffff 0",
               n, quotient, remainder);
    end
  endtask

  task automatic test_small;
    int n, nb;
    do_start(32'd3, 32'd10);
    wait_done(n, nb);
    total++;
    if (n !== 32 || quotient !== 32'd0 || remainder !== 32'd3) begin
      bad++;
      $display("FAIL small_dividend got n=%0d q=%0d r=%0d want 32 0 3",
               n, quotient, remainder);
    end
  endtask

  task automatic test_div_zero;
    int n, nb;
    do_start(32'd5, 32'd0);
    wait_done(n, nb);
    total++;
    if (n !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL dz_timing got n=%0d busy=%b want 0 0", n, busy);
    end
    total++;
    if ({quotient, remainder, div_by_zero} !== {32'hFFFF_FFFF, 32'd5, 1'b1}) begin
      bad++;
      $display("FAIL dz_result got q=%h r=%0d z=%b want ffffffff 5 1",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    total++;
    if ({done, busy, div_by_zero} !== 3'b001) begin
      bad++;
      $display("FAIL dz_after got d=%b b=%b z=%b want 0 0 1",
               done, busy, div_by_zero);
    end
  endtask

  task automatic test_dz_clear;
    int n, nb;
    do_start(32'd1000, 32'd33);
    total++;
    if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL dz_clear got z=%b busy=%b want 0 1", div_by_zero, busy);
    end
    wait_done(n, nb);
    total++;
    if (n !== 32 || quotient !== 32'd30 || remainder !== 32'd10) begin
      bad++;
      $display("FAIL div_1000_33 got n=%0d q=%0d r=%0d want 32 30 10",
               n, quotient, remainder);
    end
  endtask

  task automatic test_ignored_start;
    int n, nb;
    do_start(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    start = 1'b1;
    dividend = 32'd9;
    divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, nb);
    total++;
    if (n !== 22 || quotient !== 32'd14 || remainder !== 32'd2) begin
      bad++;
      $display("FAIL ignored_start got n=%0d q=%0d r=%0d want 22 14 2",
               n, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid;
    int n, nb, ndone;
    do_start(32'd1000, 32'd33);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
      bad++;
      $display("FAIL reset_mid got b=%b d=%b q=%h r=%h z=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL reset_mid_quiet got %0d active cycles want 0", ndone);
    end
  endtask

  task automatic test_back_to_back;
    int n, nb;
    do_start(32'd50, 32'd5);
    wait_done(n, nb);
    total++;
    if (n !== 32 || quotient !== 32'd10 || remainder !== 32'd0) begin
      bad++;
      $display("FAIL b2b_first got n=%0d q=%0d r=%0d want 32 10 0",
               n, quotient, remainder);
    end
    start = 1'b1;
    dividend = 32'd7;
    divisor = 32'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, nb);
    total++;
    if (n !== 32 || quotient !== 32'd3 || remainder !== 32'd1) begin
      bad++;
      $display("FAIL b2b_second got n=%0d q=%0d r=%0d want 32 3 1",
               n, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_small();
    test_div_zero();
    test_dz_clear();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
